adc_emu: RTL and testbench
==========================

// Module: adc_emu
// PURPOSE
//  Synthesizable device-side model of the 32-bit SAR ADC serial port, built for loopback and hardware-in-loop tests.
//  - Responds to mclk by running a conversion and driving busy/drl.
//  - Shifts the result out on sdoa/sdob on scka/sckb edges.
//  - Captures 12-bit control frames from sdi.
//  - Sits in the same clk domain as the ADC master and replaces the physical converter on the pins.
// PARAMETERS
//  CONV_CYC  20  clk cycles busy/drl stay high per conversion (must be < master mclk period)
//  W         32  sample word width on sdoa/sdob
// PORTS
//  clk          in   1   system clock
//  arst         in   1   asynchronous reset, active high
//  mclk         in   1   conversion start; rising edge detected
//  scka         in   1   serial clock A; rising edge detected
//  sckb         in   1   serial clock B; rising edge detected
//  sdi          in   1   control data, MSB first, captured on scka rising edge
//  sync         in   1   one-cycle pulse; realigns both shift pointers to MSB
//  sample_a_i   in   W   word presented on sdoa (ignored when ramp compiled in)
//  sample_b_i   in   W   word presented on sdob (ignored when ramp compiled in)
//  busy         out  1   conversion in progress
//  drl          out  1   data-ready-low: high from conversion start until the word is loaded
//  sdoa         out  1   serial data A, MSB first
//  sdob         out  1   serial data B, MSB first
//  cfg_word     out  10  last accepted control payload
//  cfg_valid    out  1   one-cycle pulse when cfg_word updates
//  conv_cnt     out  16  completed conversions, wraps at 0xFFFF->0
//  err_overrun  out  1   one-cycle pulse: mclk or scka edge seen while busy
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shift registers 0, bit counter 0.
//  Edge detection: registered previous value; edge = cur & ~prev; one clk of detection latency.
//  FSM:
//  - IDLE: mclk edge -> CONV.
//  - CONV: busy=1, drl=1, count CONV_CYC cycles, then -> LOAD.
//  - LOAD (1 cycle): busy=0, drl still 1.
//    - Load sra<=sample_a_i, srb<=sample_b_i; sdoa/sdob<=bit W-1.
//    - Clear rx bit counter; conv_cnt++.
//    - -> READY with drl=0.
//  - READY:
//    - scka edge: sdoa<=next lower bit; rx shift<={rx[10:0],sdi}; rx count++ (saturates at 15).
//    - sckb edge: sdob advances likewise.
//    - After W edges sdoa/sdob hold 0.
//    - mclk edge: if rx count==12 and rx[11:10]==2'b10, then cfg_word<=rx[9:0] and cfg_valid pulses; in all cases -> CONV.
//  - The first sdoa bit is valid from the cycle drl falls. Each advance is visible one clk after the master raises scka, so a master sampling on its next scka-high cycle reads the new bit.
//  Simultaneous events:
//  - mclk edge with scka edge in READY: process the shift first, then evaluate cfg, then -> CONV.
//  - sync with scka edge: sync wins (pointer=MSB, no advance).
//  - mclk or scka edge in CONV/LOAD: ignored, err_overrun=1 for one cycle.
//  - Frame of != 12 bits or a bad header: cfg_word unchanged, no pulse.
//  - arst mid-frame: immediate return to reset values; the next mclk starts a fresh conversion.
// CONFIGURATION
//  ADC_EMU_RAMP_EN defined:
//  - sample_a_i/sample_b_i are ignored.
//  - A is an internal W-bit ramp: 0 after reset, +1 per LOAD, wraps at 2^W-1.
//  - B is the bitwise inverse of the ramp.
//  ADC_EMU_RAMP_EN undefined:
//  - A and B come from sample_a_i/sample_b_i, sampled in LOAD.
//  - No ramp register is instantiated.
// STRUCTURE
//  adc_emu_pkg:
//  - State encoding (IDLE, CONV, LOAD, READY).
//  - CTRL_HDR=2'b10, CTRL_LEN=12.
//  - Rx-counter width.
//  Sub-module adc_emu_edge: registered rising-edge detector, instantiated for mclk, scka and sckb.
// TESTING
//  1. Reset, mclk pulse:
//     - busy/drl high for 20 cycles; drl falls 1 cycle after busy.
//     - conv_cnt=1.
//  2. sample_a_i=32'hA5A5_0F01, mclk, 32 scka pulses (1 high, 1 low):
//     - Sampled word equals 32'hA5A5_0F01.
//     - 33rd pulse reads 0.
//  3. 12-bit frame {2'b10,10'h2C3} on sdi, then mclk:
//     - cfg_valid pulses once; cfg_word=10'h2C3.
//  4. Frame with header 2'b01, or only 11 bits, then mclk:
//     - No cfg_valid; cfg_word unchanged.
//  5. mclk during CONV: err_overrun pulses, conversion timing unaffected.
//     scka during CONV: err_overrun pulses, sdoa unchanged.
//  6. Ramp macro: 3 conversions read 0,1,2 on A and FFFF_FFFF, FFFF_FFFE, FFFF_FFFD on B.
//     Assert arst mid-readout: all outputs 0 immediately.

Source files
------------

// File: rtl/adc_emu_pkg.sv
// Shared constants for the SAR ADC serial-port emulator: state codes, control-frame format, counter widths.
package adc_emu_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CONV  = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;
   localparam logic [1:0] ST_READY = 2'd3;

   localparam logic [1:0] CTRL_HDR   = 2'b10;
   localparam int         CTRL_LEN   = 12;
   localparam int         CFG_W      = CTRL_LEN - 2;
   localparam int         CONV_CNT_W = 16;
   localparam int         RX_CNT_W   = 4;

   typedef logic [RX_CNT_W-1:0] rx_cnt_t;

   // A frame is accepted only with exactly CTRL_LEN bits and the expected header.
   function automatic logic frame_ok(input logic [1:0] hdr, input rx_cnt_t cnt);
      return (cnt == rx_cnt_t'(CTRL_LEN)) && (hdr == CTRL_HDR);
   endfunction

endpackage

// File: rtl/adc_emu_if.sv
// Pin bundle between the ADC master and the emulator; master drives strobes/data, slave drives status/serial out.
interface adc_emu_if
   import adc_emu_pkg::*;
#(
   parameter int W = 32
);
   logic                  mclk;
   logic                  scka;
   logic                  sckb;
   logic                  sdi;
   logic                  sync;
   logic [W-1:0]          sample_a_i;
   logic [W-1:0]          sample_b_i;
   logic                  busy;
   logic                  drl;
   logic                  sdoa;
   logic                  sdob;
   logic [CFG_W-1:0]      cfg_word;
   logic                  cfg_valid;
   logic [CONV_CNT_W-1:0] conv_cnt;
   logic                  err_overrun;

   modport master (
      output mclk, scka, sckb, sdi, sync, sample_a_i, sample_b_i,
      input  busy, drl, sdoa, sdob, cfg_word, cfg_valid, conv_cnt, err_overrun
   );

   modport slave (
      input  mclk, scka, sckb, sdi, sync, sample_a_i, sample_b_i,
      output busy, drl, sdoa, sdob, cfg_word, cfg_valid, conv_cnt, err_overrun
   );
endinterface

// File: rtl/adc_emu_edge.sv
// Registered rising-edge detector; the pulse is combinational from the live input so the
// consuming register acts on the clk edge that first samples the input high.
module adc_emu_edge (
   input  logic clk,
   input  logic rst,
   input  logic in_i,
   output logic rise_o
);
   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= in_i;
   end

   assign rise_o = in_i & ~prev_q;
endmodule

// File: rtl/adc_emu.sv
// Device-side model of the 32-bit SAR ADC serial port. Define ADC_EMU_RAMP_EN to replace
// the sample inputs with an internal ramp (A) and its inverse (B).
//
//   state | meaning
//   IDLE  | waiting for the first mclk edge after reset
//   CONV  | busy/drl high, CONV_CYC-cycle down-counter running
//   LOAD  | one cycle: capture words, clear rx counter, bump conv_cnt
//   READY | shifting sdoa/sdob, capturing sdi; mclk edge checks frame and restarts
module adc_emu
   import adc_emu_pkg::*;
#(
   parameter int CONV_CYC = 20,
   parameter int W        = 32
) (
   input  logic     clk,
   input  logic     arst,
   adc_emu_if.slave bus
);
   localparam int TW = (CONV_CYC > 1) ? $clog2(CONV_CYC) : 1;

   logic                  mclk_rise, scka_rise, sckb_rise;
   logic [1:0]            state_q, state_d;
   logic [TW-1:0]         tmr_q, tmr_d;
   logic [W-1:0]          word_a_q, word_a_d, word_b_q, word_b_d;
   logic [W-1:0]          sr_a_q, sr_a_d, sr_b_q, sr_b_d;
   logic [CTRL_LEN-1:0]   rx_q, rx_d, rx_shift;
   rx_cnt_t               rx_cnt_q, rx_cnt_d, rx_cnt_inc;
   logic [CFG_W-1:0]      cfg_word_q, cfg_word_d;
   logic                  cfg_valid_q, cfg_valid_d;
   logic [CONV_CNT_W-1:0] conv_cnt_q, conv_cnt_d;
   logic                  err_q, err_d;
   logic [W-1:0]          load_a, load_b;

   adc_emu_edge u_edge_mclk (.clk(clk), .rst(arst), .in_i(bus.mclk), .rise_o(mclk_rise));
   adc_emu_edge u_edge_scka (.clk(clk), .rst(arst), .in_i(bus.scka), .rise_o(scka_rise));
   adc_emu_edge u_edge_sckb (.clk(clk), .rst(arst), .in_i(bus.sckb), .rise_o(sckb_rise));

`ifdef ADC_EMU_RAMP_EN
   logic [W-1:0] ramp_q, ramp_d;
   logic         unused_samples;

   assign ramp_d         = (state_q == ST_LOAD) ? ramp_q + W'(1) : ramp_q;
   assign load_a         = ramp_q;
   assign load_b         = ~ramp_q;
   assign unused_samples = ^{bus.sample_a_i, bus.sample_b_i};

   always_ff @(posedge clk or posedge arst) begin
      if (arst) ramp_q <= '0;
      else      ramp_q <= ramp_d;
   end
`else
   assign load_a = bus.sample_a_i;
   assign load_b = bus.sample_b_i;
`endif

   assign rx_shift   = {rx_q[CTRL_LEN-2:0], bus.sdi};
   assign rx_cnt_inc = (rx_cnt_q == '1) ? rx_cnt_q : rx_cnt_q + rx_cnt_t'(1);

   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      word_a_d    = word_a_q;
      word_b_d    = word_b_q;
      sr_a_d      = sr_a_q;
      sr_b_d      = sr_b_q;
      rx_d        = rx_q;
      rx_cnt_d    = rx_cnt_q;
      cfg_word_d  = cfg_word_q;
      cfg_valid_d = 1'b0;
      conv_cnt_d  = conv_cnt_q;
      err_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mclk_rise) begin
               state_d = ST_CONV;
               tmr_d   = TW'(CONV_CYC - 1);
            end
         end
         ST_CONV: begin
            err_d = mclk_rise | scka_rise;
            if (tmr_q == '0) state_d = ST_LOAD;
            else             tmr_d   = tmr_q - TW'(1);
         end
         ST_LOAD: begin
            err_d      = mclk_rise | scka_rise;
            word_a_d   = load_a;
            word_b_d   = load_b;
            sr_a_d     = load_a;
            sr_b_d     = load_b;
            rx_cnt_d   = '0;
            conv_cnt_d = conv_cnt_q + CONV_CNT_W'(1);
            state_d    = ST_READY;
         end
         ST_READY: begin
            if (scka_rise) begin
               rx_d     = rx_shift;
               rx_cnt_d = rx_cnt_inc;
            end
            // sync reloads the held words so both pointers restart at the MSB
            if (bus.sync) begin
               sr_a_d = word_a_q;
               sr_b_d = word_b_q;
            end else begin
               if (scka_rise) sr_a_d = {sr_a_q[W-2:0], 1'b0};
               if (sckb_rise) sr_b_d = {sr_b_q[W-2:0], 1'b0};
            end
            if (mclk_rise) begin
               if (frame_ok(rx_d[CTRL_LEN-1 -: 2], rx_cnt_d)) begin
                  cfg_word_d  = rx_d[CFG_W-1:0];
                  cfg_valid_d = 1'b1;
               end
               state_d = ST_CONV;
               tmr_d   = TW'(CONV_CYC - 1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q     <= ST_IDLE;
         tmr_q       <= '0;
         word_a_q    <= '0;
         word_b_q    <= '0;
         sr_a_q      <= '0;
         sr_b_q      <= '0;
         rx_q        <= '0;
         rx_cnt_q    <= '0;
         cfg_word_q  <= '0;
         cfg_valid_q <= 1'b0;
         conv_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         word_a_q    <= word_a_d;
         word_b_q    <= word_b_d;
         sr_a_q      <= sr_a_d;
         sr_b_q      <= sr_b_d;
         rx_q        <= rx_d;
         rx_cnt_q    <= rx_cnt_d;
         cfg_word_q  <= cfg_word_d;
         cfg_valid_q <= cfg_valid_d;
         conv_cnt_q  <= conv_cnt_d;
         err_q       <= err_d;
      end
   end

   assign bus.busy        = (state_q == ST_CONV);
   assign bus.drl         = (state_q == ST_CONV) || (state_q == ST_LOAD);
   assign bus.sdoa        = sr_a_q[W-1];
   assign bus.sdob        = sr_b_q[W-1];
   assign bus.cfg_word    = cfg_word_q;
   assign bus.cfg_valid   = cfg_valid_q;
   assign bus.conv_cnt    = conv_cnt_q;
   assign bus.err_overrun = err_q;
endmodule

// File: tb/tb_adc_emu.sv
// Self-checking bench for adc_emu: frame table, hand-written corner sequences and randomized
// conversions compared against a word/frame-level reference model.
module tb_adc_emu;
   localparam int W        = 32;
   localparam int CONV_CYC = 20;

   typedef struct {
      int          len;
      logic [15:0] bits;
      logic [W-1:0] samp;
      bit          exp_valid;
      logic [9:0]  exp_word;
   } vec_t;

   logic clk  = 1'b0;
   logic arst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [W-1:0] m_word_a, m_word_b, m_ramp;
   logic [15:0]  m_conv;
   logic [9:0]   m_cfg;
   bit           rxq[$];
   vec_t         vt[8];

   always #5 clk = ~clk;

   adc_emu_if #(.W(W)) bus ();
   adc_emu #(.CONV_CYC(CONV_CYC), .W(W)) dut (.clk(clk), .arst(arst), .bus(bus));

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_word_a = '0;
      m_word_b = '0;
      m_ramp   = '0;
      m_conv   = '0;
      m_cfg    = '0;
      rxq.delete();
   endtask

   task automatic model_load();
`ifdef ADC_EMU_RAMP_EN
      m_word_a = m_ramp;
      m_word_b = ~m_ramp;
      m_ramp   = m_ramp + 1;
`else
      m_word_a = bus.sample_a_i;
      m_word_b = bus.sample_b_i;
`endif
      m_conv = m_conv + 1;
   endtask

   function automatic logic [39:0] exp_read(input logic [W-1:0] w, input int n, input int sync_at);
      logic [39:0] r;
      int idx;
      r = '0;
      for (int p = 0; p < n; p++) begin
         idx = (sync_at >= 0 && p > sync_at) ? p - sync_at - 1 : p;
         r[n-1-p] = (idx < W) ? w[W-1-idx] : 1'b0;
      end
      return r;
   endfunction

   // mclk pulse plus full conversion; optional overrun injections at sample index inj_m/inj_s
   task automatic run_conv(input int inj_m, input int inj_s, input bit s_with_m, input bit s_bit,
                           output int nbusy, output int ndrl, output int nvalid, output int nerr,
                           output int nchg, output bit exp_valid);
      logic s0;
      bit   seen, done;
      nbusy = 0; ndrl = 0; nvalid = 0; nerr = 0; nchg = 0; seen = 0; done = 0;
      s0 = bus.sdoa;
      if (s_with_m) rxq.push_back(s_bit);
      exp_valid = (rxq.size() == 12) && rxq[0] && !rxq[1];
      if (exp_valid)
         for (int k = 0; k < 10; k++) m_cfg[9-k] = rxq[2+k];
      rxq.delete();
      bus.mclk = 1'b1; bus.scka = s_with_m; bus.sdi = s_bit;
      step();
      bus.mclk = 1'b0; bus.scka = 1'b0;
      for (int i = 0; i < 60; i++) begin
         nbusy  += int'(bus.busy);
         ndrl   += int'(bus.drl);
         nvalid += int'(bus.cfg_valid);
         nerr   += int'(bus.err_overrun);
         if (bus.busy && bus.sdoa !== s0) nchg++;
         if (bus.drl) seen = 1;
         else if (seen) begin
            done = 1;
            break;
         end
         bus.mclk = (i == inj_m);
         bus.scka = (i == inj_s);
         step();
      end
      bus.mclk = 1'b0; bus.scka = 1'b0;
      check("conv_done", 64'(done), 64'd1);
      model_load();
   endtask

   task automatic conv_chk(input string name);
      int  nb, nd, nv, ne, nc;
      bit  ev;
      run_conv(-1, -1, 0, 0, nb, nd, nv, ne, nc, ev);
      check({name, "_cfg_valid"}, 64'(nv), 64'(ev));
      check({name, "_cfg_word"}, 64'(bus.cfg_word), 64'(m_cfg));
      check({name, "_conv_cnt"}, 64'(bus.conv_cnt), 64'(m_conv));
      check({name, "_err"}, 64'(ne), 64'd0);
   endtask

   task automatic pulses(input int n, input logic [39:0] sdi_bits, input int sync_at,
                         output logic [39:0] ra, output logic [39:0] rb);
      ra = '0; rb = '0;
      for (int p = 0; p < n; p++) begin
         bus.scka = 1'b1; bus.sckb = 1'b1;
         bus.sdi  = sdi_bits[n-1-p];
         bus.sync = (p == sync_at);
         ra[n-1-p] = bus.sdoa;
         rb[n-1-p] = bus.sdob;
         rxq.push_back(sdi_bits[n-1-p]);
         step();
         bus.scka = 1'b0; bus.sckb = 1'b0; bus.sync = 1'b0;
         step();
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {bus.busy, bus.drl, bus.sdoa, bus.sdob, bus.cfg_word, bus.cfg_valid,
              bus.conv_cnt, bus.err_overrun};
   endfunction

   initial begin
      int          nb, nd, nv, ne, nc, n;
      bit          ev;
      logic [39:0] ra, rb, bits;

      vt[0] = '{12, 16'({2'b10, 10'h2C3}), 32'hA5A5_0F01, 1'b1, 10'h2C3};
      vt[1] = '{12, 16'({2'b01, 10'h155}), 32'hDEAD_BEEF, 1'b0, 10'h2C3};
      vt[2] = '{11, 16'(11'b10110000110),  32'h8000_0001, 1'b0, 10'h2C3};
      vt[3] = '{13, 16'(13'b1100000111100), 32'h7FFF_FFFE, 1'b0, 10'h2C3};
      vt[4] = '{12, 16'({2'b10, 10'h3FF}), 32'hFFFF_FFFF, 1'b1, 10'h3FF};
      vt[5] = '{0,  16'h0000,              32'h0000_0000, 1'b0, 10'h3FF};
      vt[6] = '{12, 16'({2'b11, 10'h0AA}), 32'h1357_9BDF, 1'b0, 10'h3FF};
      vt[7] = '{12, 16'({2'b10, 10'h000}), 32'h2468_ACE0, 1'b1, 10'h000};

      bus.mclk = 0; bus.scka = 0; bus.sckb = 0; bus.sdi = 0; bus.sync = 0;
      bus.sample_a_i = '0; bus.sample_b_i = '0;
      model_reset();
      step(); step();
      arst = 1'b0;
      step();
      check("reset_outputs", 64'(all_outs()), 64'd0);

      // conversion timing
      bus.sample_a_i = 32'hA5A5_0F01; bus.sample_b_i = 32'h1234_5678;
      run_conv(-1, -1, 0, 0, nb, nd, nv, ne, nc, ev);
      check("busy_cycles", 64'(nb), 64'd20);
      check("drl_cycles", 64'(nd), 64'd21);
      check("first_conv_cfg_valid", 64'(nv), 64'd0);
      check("first_conv_conv_cnt", 64'(bus.conv_cnt), 64'd1);

      // full readout plus one extra pulse
      pulses(33, '0, -1, ra, rb);
      check("read_a_33", ra, exp_read(m_word_a, 33, -1));
      check("read_b_33", rb, exp_read(m_word_b, 33, -1));
`ifndef ADC_EMU_RAMP_EN
      check("read_a_word", 64'(ra[32:1]), 64'h0000_0000_A5A5_0F01);
`endif
      check("read_a_33rd", 64'(ra[0]), 64'd0);

      // sync realignment, alone and coincident with scka
      conv_chk("sync_prep");
      pulses(5, '0, -1, ra, rb);
      bus.sync = 1'b1; step(); bus.sync = 1'b0;
      pulses(32, '0, -1, ra, rb);
      check("sync_alone_a", ra, exp_read(m_word_a, 32, -1));
      check("sync_alone_b", rb, exp_read(m_word_b, 32, -1));
      bus.sync = 1'b1; step(); bus.sync = 1'b0;
      pulses(8, '0, 3, ra, rb);
      check("sync_with_scka_a", ra, exp_read(m_word_a, 8, 3));
      check("sync_with_scka_b", rb, exp_read(m_word_b, 8, 3));

      // frame table
      conv_chk("table_prep");
      for (int r = 0; r < 8; r++) begin
         pulses(vt[r].len, 40'(vt[r].bits), -1, ra, rb);
         if (vt[r].len > 0) check($sformatf("table%0d_read_a", r), ra, exp_read(m_word_a, vt[r].len, -1));
         bus.sample_a_i = vt[r].samp;
         bus.sample_b_i = {vt[r].samp[15:0], vt[r].samp[31:16]};
         run_conv(-1, -1, 0, 0, nb, nd, nv, ne, nc, ev);
         check($sformatf("table%0d_cfg_valid", r), 64'(nv), 64'(vt[r].exp_valid));
         check($sformatf("table%0d_cfg_word", r), 64'(bus.cfg_word), 64'(vt[r].exp_word));
      end

      // last frame bit arrives on the same cycle as mclk
      bits = 40'({2'b10, 10'h1A5});
      pulses(11, bits >> 1, -1, ra, rb);
      run_conv(-1, -1, 1, bits[0], nb, nd, nv, ne, nc, ev);
      check("simul_cfg_valid", 64'(nv), 64'd1);
      check("simul_cfg_word", 64'(bus.cfg_word), 64'h1A5);

      // overrun: mclk and scka during CONV
      bus.sample_a_i = 32'hAAAA_AAAA; bus.sample_b_i = 32'h5555_5555;
      conv_chk("overrun_prep");
      run_conv(3, 8, 0, 0, nb, nd, nv, ne, nc, ev);
      check("overrun_err_pulses", 64'(ne), 64'd2);
      check("overrun_busy_cycles", 64'(nb), 64'd20);
      check("overrun_drl_cycles", 64'(nd), 64'd21);
      check("overrun_sdoa_held", 64'(nc), 64'd0);
      pulses(32, '0, -1, ra, rb);
      check("overrun_read_a", ra, exp_read(m_word_a, 32, -1));

      // randomized conversions and frames
      conv_chk("rand_prep");
      for (int it = 0; it < 30; it++) begin
         bus.sample_a_i = $urandom; bus.sample_b_i = $urandom;
         conv_chk($sformatf("rand%0d", it));
         if ($urandom_range(0, 1) == 1) begin
            n = 12;
            bits = '0;
            bits[11:0] = {2'b10, 10'($urandom)};
         end else begin
            n = $urandom_range(0, 40);
            bits = {8'($urandom), 32'($urandom)};
         end
         pulses(n, bits, -1, ra, rb);
         if (n > 0) begin
            check($sformatf("rand%0d_read_a", it), ra, exp_read(m_word_a, n, -1));
            check($sformatf("rand%0d_read_b", it), rb, exp_read(m_word_b, n, -1));
         end
      end
      conv_chk("rand_final");

      // asynchronous reset mid-readout
      pulses(10, 40'h2AA, -1, ra, rb);
      #2 arst = 1'b1;
      #1 check("arst_immediate", 64'(all_outs()), 64'd0);
      step(); step();
      arst = 1'b0;
      model_reset();
      step();
      bus.sample_a_i = 32'hC0DE_0001; bus.sample_b_i = 32'h0BAD_F00D;
      for (int k = 0; k < 3; k++) begin
         conv_chk($sformatf("post_arst%0d", k));
         pulses(32, '0, -1, ra, rb);
         check($sformatf("post_arst%0d_read_a", k), ra, exp_read(m_word_a, 32, -1));
         check($sformatf("post_arst%0d_read_b", k), rb, exp_read(m_word_b, 32, -1));
`ifdef ADC_EMU_RAMP_EN
         check($sformatf("ramp%0d_a", k), 64'(ra[31:0]), 64'(32'(k)));
         check($sformatf("ramp%0d_b", k), 64'(rb[31:0]), 64'(~32'(k)));
`endif
      end
      check("post_arst_conv_cnt", 64'(bus.conv_cnt), 64'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
